// File: rtl/controller_pipe_m_if.sv
`default_nettype none
// ============================================================================
// Module   : controller_pipe_m_if
// Brief    : D/E-stage inputs and pipelined control outputs of the RV32I/M
//            controller, bundled for the datapath and hazard unit.
// Revision : 1.0  initial release
// ============================================================================
interface controller_pipe_m_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       funct7b0;
    logic       zeroe;
    logic       signe;
    logic       overfe;
    logic       carrye;
    logic       flushe;
    logic [2:0] immsrcd;
    logic       alusrcae;
    logic [1:0] alusrcbe;
    logic [3:0] alucontrole;
    logic       resultsrce0;
    logic       pcsrce;
    logic       pcjalsrce;
    logic       memwritem;
    logic       regwritem;
    logic       regwritew;
    logic [1:0] resultsrcw;
    logic       mdstarte;
    logic [2:0] mdfunce;
    logic       mdbusye;

    // Controller side
    modport slave (
        input  op, funct3, funct7b5, funct7b0,
        input  zeroe, signe, overfe, carrye, flushe,
        output immsrcd, alusrcae, alusrcbe, alucontrole, resultsrce0,
        output pcsrce, pcjalsrce, memwritem, regwritem, regwritew,
        output resultsrcw, mdstarte, mdfunce, mdbusye
    );

    // Datapath / hazard-unit side
    modport master (
        output op, funct3, funct7b5, funct7b0,
        output zeroe, signe, overfe, carrye, flushe,
        input  immsrcd, alusrcae, alusrcbe, alucontrole, resultsrce0,
        input  pcsrce, pcjalsrce, memwritem, regwritem, regwritew,
        input  resultsrcw, mdstarte, mdfunce, mdbusye
    );
endinterface
`default_nettype wire

// File: rtl/controller_pipe_m.sv
`default_nettype none
// ============================================================================
// Module   : controller_pipe_m
// Brief    : Pipelined RV32I/M control unit: D-stage decode, E/M/W control
//            registers, full branch resolution and a mul/div hold sequencer.
// Revision : 1.0  initial release
// ============================================================================
module controller_pipe_m #(
    parameter int MEXT   = 1,
    parameter int MULLAT = 2,
    parameter int DIVLAT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    controller_pipe_m_if.slave   bus
);

    localparam logic [3:0] c_alu_add   = 4'b0000;
    localparam logic [3:0] c_alu_sub   = 4'b0001;
    localparam logic [3:0] c_alu_and   = 4'b0010;
    localparam logic [3:0] c_alu_or    = 4'b0011;
    localparam logic [3:0] c_alu_xor   = 4'b0100;
    localparam logic [3:0] c_alu_slt   = 4'b0101;
    localparam logic [3:0] c_alu_sltu  = 4'b0110;
    localparam logic [3:0] c_alu_sll   = 4'b0111;
    localparam logic [3:0] c_alu_srl   = 4'b1000;
    localparam logic [3:0] c_alu_sra   = 4'b1001;
    localparam logic [3:0] c_alu_passb = 4'b1010;

    localparam logic [7:0] c_mul_lat = 8'(MULLAT);
    localparam logic [7:0] c_div_lat = 8'(DIVLAT);

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [3:0] alucontrol;
        logic       md;
        logic [2:0] funct3;
    } ctrl_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    ctrl_t      w_ctrl_d;
    ctrl_t      r_e;
    logic [2:0] w_immsrc_d;
    logic [3:0] w_alu_op;
    logic       r_regwrite_m;
    logic       r_memwrite_m;
    logic [1:0] r_resultsrc_m;
    logic       r_regwrite_w;
    logic [1:0] r_resultsrc_w;
    logic       w_taken;
    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [7:0] w_lat;
    logic       w_hold_e;
    logic       w_mdstart;
    logic       w_mdbusy;

    // Shared R/I ALU decode; funct7b5 selects SUB only for register ops
    always_comb begin
        w_alu_op = c_alu_add;
        case (bus.funct3)
            3'b000: w_alu_op = (bus.op[5] && bus.funct7b5) ? c_alu_sub : c_alu_add;
            3'b001: w_alu_op = c_alu_sll;
            3'b010: w_alu_op = c_alu_slt;
            3'b011: w_alu_op = c_alu_sltu;
            3'b100: w_alu_op = c_alu_xor;
            3'b101: w_alu_op = bus.funct7b5 ? c_alu_sra : c_alu_srl;
            3'b110: w_alu_op = c_alu_or;
            default: w_alu_op = c_alu_and;
        endcase
    end

    always_comb begin
        w_ctrl_d   = '0;
        w_immsrc_d = 3'b000;
        case (bus.op)
            7'b0000011: begin
                w_ctrl_d.regwrite  = 1'b1;
                w_ctrl_d.alusrcb   = 2'b01;
                w_ctrl_d.resultsrc = 2'b01;
            end
            7'b0100011: begin
                w_ctrl_d.memwrite = 1'b1;
                w_ctrl_d.alusrcb  = 2'b01;
                w_immsrc_d        = 3'b001;
            end
            7'b0110011: begin
                if (bus.funct7b0) begin
                    if (MEXT != 0) begin
                        w_ctrl_d.regwrite  = 1'b1;
                        w_ctrl_d.resultsrc = 2'b11;
                        w_ctrl_d.md        = 1'b1;
                        w_ctrl_d.funct3    = bus.funct3;
                    end
                end else begin
                    w_ctrl_d.regwrite   = 1'b1;
                    w_ctrl_d.alucontrol = w_alu_op;
                end
            end
            7'b0010011: begin
                w_ctrl_d.regwrite   = 1'b1;
                w_ctrl_d.alusrcb    = 2'b01;
                w_ctrl_d.alucontrol = w_alu_op;
            end
            7'b1100011: begin
                w_ctrl_d.branch     = 1'b1;
                w_ctrl_d.alucontrol = c_alu_sub;
                w_ctrl_d.funct3     = bus.funct3;
                w_immsrc_d          = 3'b010;
            end
            7'b1101111: begin
                w_ctrl_d.regwrite  = 1'b1;
                w_ctrl_d.jump      = 1'b1;
                w_ctrl_d.resultsrc = 2'b10;
                w_immsrc_d         = 3'b011;
            end
            7'b1100111: begin
                w_ctrl_d.regwrite  = 1'b1;
                w_ctrl_d.jump      = 1'b1;
                w_ctrl_d.jalr      = 1'b1;
                w_ctrl_d.alusrcb   = 2'b01;
                w_ctrl_d.resultsrc = 2'b10;
            end
            7'b0110111: begin
                w_ctrl_d.regwrite   = 1'b1;
                w_ctrl_d.alusrcb    = 2'b01;
                w_ctrl_d.alucontrol = c_alu_passb;
                w_immsrc_d          = 3'b100;
            end
            7'b0010111: begin
                w_ctrl_d.regwrite = 1'b1;
                w_ctrl_d.alusrca  = 1'b1;
                w_ctrl_d.alusrcb  = 2'b01;
                w_immsrc_d        = 3'b100;
            end
            default: begin
                w_ctrl_d   = '0;
                w_immsrc_d = 3'b000;
            end
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_e.funct3)
            3'b000: w_taken = bus.zeroe;
            3'b001: w_taken = !bus.zeroe;
            3'b100: w_taken = bus.signe ^ bus.overfe;
            3'b101: w_taken = !(bus.signe ^ bus.overfe);
            3'b110: w_taken = !bus.carrye;
            3'b111: w_taken = bus.carrye;
            default: w_taken = 1'b0;
        endcase
    end

    // The op is held in E from its first cycle; mdbusye only covers cycles 2..LAT
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hold_e     = 1'b0;
        w_mdstart    = 1'b0;
        w_mdbusy     = 1'b0;
        w_lat        = r_e.funct3[2] ? c_div_lat : c_mul_lat;
        case (r_state)
            S_IDLE: begin
                if (r_e.md) begin
                    w_mdstart = 1'b1;
                    if (w_lat != 8'd1) begin
                        w_hold_e     = 1'b1;
                        w_cnt_next   = w_lat - 8'd1;
                        w_state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_mdbusy   = 1'b1;
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_hold_e = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A held E stage has priority over flushe and feeds bubbles into M
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e           <= '0;
            r_regwrite_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_resultsrc_m <= 2'b00;
            r_regwrite_w  <= 1'b0;
            r_resultsrc_w <= 2'b00;
        end else begin
            if (!w_hold_e) begin
                r_e <= bus.flushe ? '0 : w_ctrl_d;
            end
            r_regwrite_m  <= w_hold_e ? 1'b0 : r_e.regwrite;
            r_memwrite_m  <= w_hold_e ? 1'b0 : r_e.memwrite;
            r_resultsrc_m <= w_hold_e ? 2'b00 : r_e.resultsrc;
            r_regwrite_w  <= r_regwrite_m;
            r_resultsrc_w <= r_resultsrc_m;
        end
    end

    assign bus.immsrcd     = w_immsrc_d;
    assign bus.alusrcae    = r_e.alusrca;
    assign bus.alusrcbe    = r_e.alusrcb;
    assign bus.alucontrole = r_e.alucontrol;
    assign bus.resultsrce0 = r_e.resultsrc[0];
    assign bus.pcsrce      = (r_e.branch & w_taken) | r_e.jump;
    assign bus.pcjalsrce   = r_e.jalr & r_e.jump;
    assign bus.memwritem   = r_memwrite_m;
    assign bus.regwritem   = r_regwrite_m;
    assign bus.regwritew   = r_regwrite_w;
    assign bus.resultsrcw  = r_resultsrc_w;
    assign bus.mdstarte    = w_mdstart;
    assign bus.mdfunce     = r_e.md ? r_e.funct3 : 3'b000;
    assign bus.mdbusye     = w_mdbusy;

endmodule
`default_nettype wire

// File: tb/tb_controller_pipe_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller_pipe_m
// Brief    : Directed self-checking bench for controller_pipe_m (MEXT=1 and
//            MEXT=0 instances driven with identical D-stage stimulus).
// Revision : 1.0  initial release
// ============================================================================
module tb_controller_pipe_m;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    controller_pipe_m_if bus ();
    controller_pipe_m_if bus_n ();

    assign bus_n.op       = bus.op;
    assign bus_n.funct3   = bus.funct3;
    assign bus_n.funct7b5 = bus.funct7b5;
    assign bus_n.funct7b0 = bus.funct7b0;
    assign bus_n.zeroe    = bus.zeroe;
    assign bus_n.signe    = bus.signe;
    assign bus_n.overfe   = bus.overfe;
    assign bus_n.carrye   = bus.carrye;
    assign bus_n.flushe   = bus.flushe;

    controller_pipe_m #(.MEXT(1), .MULLAT(2), .DIVLAT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    controller_pipe_m #(.MEXT(0), .MULLAT(2), .DIVLAT(8)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [6:0] o, input logic [2:0] f3,
                           input logic f5, input logic f0);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f5;
        bus.funct7b0 = f0;
        #1;
    endtask

    task automatic nop;
        present(7'b0000000, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic set_flags(input logic z, input logic s, input logic o, input logic c);
        bus.zeroe  = z;
        bus.signe  = s;
        bus.overfe = o;
        bus.carrye = c;
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        bus.flushe = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        present(7'b0110011, 3'b000, 1'b1, 1'b0);
        tick;
        tick;
        check("rst_regwritew",  4'(bus.regwritew),   4'd0);
        check("rst_regwritem",  4'(bus.regwritem),   4'd0);
        check("rst_alucontrol", bus.alucontrole,     4'd0);
        check("rst_pcsrce",     4'(bus.pcsrce),      4'd0);
        check("rst_mdbusye",    4'(bus.mdbusye),     4'd0);
        check("rst_mdstarte",   4'(bus.mdstarte),    4'd0);
        check("rst_mdfunce",    4'(bus.mdfunce),     4'd0);
        check("rst_resultsrcw", 4'(bus.resultsrcw),  4'd0);
        reset = 1'b1;

        // LW through all stages
        present(7'b0000011, 3'b010, 1'b0, 1'b0);
        check("lw_immsrcd", 4'(bus.immsrcd), 4'd0);
        tick;
        check("lw_alu_e",    bus.alucontrole,      4'd0);
        check("lw_srcb_e",   4'(bus.alusrcbe),     4'd1);
        check("lw_rsrc0_e",  4'(bus.resultsrce0),  4'd1);
        nop;
        tick;
        check("lw_regwritem", 4'(bus.regwritem), 4'd1);
        check("lw_memwritem", 4'(bus.memwritem), 4'd0);
        tick;
        check("lw_regwritew",  4'(bus.regwritew),  4'd1);
        check("lw_resultsrcw", 4'(bus.resultsrcw), 4'd1);

        present(7'b0100011, 3'b010, 1'b0, 1'b0);
        check("sw_immsrcd", 4'(bus.immsrcd), 4'd1);
        tick;
        check("sw_srcb_e", 4'(bus.alusrcbe), 4'd1);
        nop;
        tick;
        check("sw_memwritem", 4'(bus.memwritem), 4'd1);
        check("sw_regwritem", 4'(bus.regwritem), 4'd0);

        // ALU decode
        present(7'b0110011, 3'b000, 1'b1, 1'b0); tick; check("sub_alu",   bus.alucontrole, 4'b0001);
        present(7'b0010011, 3'b000, 1'b1, 1'b0); tick; check("addi_alu",  bus.alucontrole, 4'b0000);
        present(7'b0010011, 3'b101, 1'b1, 1'b0); tick; check("srai_alu",  bus.alucontrole, 4'b1001);
        present(7'b0110011, 3'b011, 1'b0, 1'b0); tick; check("sltu_alu",  bus.alucontrole, 4'b0110);
        present(7'b0110111, 3'b000, 1'b0, 1'b0);
        check("lui_immsrcd", 4'(bus.immsrcd), 4'd4);
        tick;
        check("lui_alu", bus.alucontrole, 4'b1010);
        present(7'b0010111, 3'b000, 1'b0, 1'b0); tick; check("auipc_srca", 4'(bus.alusrcae), 4'd1);

        // Branches
        present(7'b1100011, 3'b001, 1'b0, 1'b0);
        check("b_immsrcd", 4'(bus.immsrcd), 4'd2);
        tick;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        check("bne_alu",     bus.alucontrole,    4'b0001);
        check("bne_pcsrc",   4'(bus.pcsrce),     4'd1);
        check("bne_pcjal",   4'(bus.pcjalsrce),  4'd0);
        present(7'b1100011, 3'b110, 1'b0, 1'b0); tick;
        set_flags(1'b0, 1'b0, 1'b0, 1'b1);
        check("bltu_pcsrc", 4'(bus.pcsrce), 4'd0);
        present(7'b1100011, 3'b101, 1'b0, 1'b0); tick;
        set_flags(1'b0, 1'b1, 1'b1, 1'b0);
        check("bge_pcsrc", 4'(bus.pcsrce), 4'd1);
        present(7'b1100011, 3'b100, 1'b0, 1'b0); tick;
        check("blt_pcsrc", 4'(bus.pcsrce), 4'd0);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);

        present(7'b1101111, 3'b000, 1'b0, 1'b0);
        check("jal_immsrcd", 4'(bus.immsrcd), 4'd3);
        tick;
        check("jal_pcsrc", 4'(bus.pcsrce),    4'd1);
        check("jal_pcjal", 4'(bus.pcjalsrce), 4'd0);
        present(7'b1100111, 3'b000, 1'b0, 1'b0); tick;
        check("jalr_pcsrc", 4'(bus.pcsrce),    4'd1);
        check("jalr_pcjal", 4'(bus.pcjalsrce), 4'd1);
        nop;
        tick;
        tick;
        check("jalr_regwritew",  4'(bus.regwritew),  4'd1);
        check("jalr_resultsrcw", 4'(bus.resultsrcw), 4'd2);

        // Flush outside a mul/div hold
        present(7'b0110011, 3'b000, 1'b1, 1'b0);
        bus.flushe = 1'b1;
        tick;
        bus.flushe = 1'b0;
        check("flush_alu", bus.alucontrole, 4'd0);
        nop;
        tick;
        check("flush_regwritem", 4'(bus.regwritem), 4'd0);
        tick;
        tick;

        // DIV with DIVLAT=8
        present(7'b0110011, 3'b100, 1'b0, 1'b1);
        tick;
        check("div_start_c1",  4'(bus.mdstarte),   4'd1);
        check("div_busy_c1",   4'(bus.mdbusye),    4'd0);
        check("div_func_c1",   4'(bus.mdfunce),    4'd4);
        check("div_alu_c1",    bus.alucontrole,    4'd0);
        check("nomext_start",  4'(bus_n.mdstarte), 4'd0);
        nop;
        for (int k = 2; k <= 8; k++) begin
            tick;
            check("div_busy",      4'(bus.mdbusye),   4'd1);
            check("div_start_off", 4'(bus.mdstarte),  4'd0);
            check("div_bubble_m",  4'(bus.regwritem), 4'd0);
            if (k == 3) bus.flushe = 1'b1;
            if (k == 5) bus.flushe = 1'b0;
        end
        check("nomext_busy", 4'(bus_n.mdbusye), 4'd0);
        tick;
        check("div_busy_c9",     4'(bus.mdbusye),   4'd0);
        check("div_regwritem_9", 4'(bus.regwritem), 4'd1);
        tick;
        check("div_regwritew_10",  4'(bus.regwritew),   4'd1);
        check("div_resultsrcw_10", 4'(bus.resultsrcw),  4'd3);
        check("nomext_regwritew",  4'(bus_n.regwritew), 4'd0);
        tick;
        tick;

        // Reset during the third busy cycle of a DIV
        present(7'b0110011, 3'b100, 1'b0, 1'b1);
        tick;
        nop;
        tick;
        tick;
        tick;
        check("rdiv_busy_c4", 4'(bus.mdbusye), 4'd1);
        reset = 1'b0;
        tick;
        check("rdiv_busy",      4'(bus.mdbusye),   4'd0);
        check("rdiv_start",     4'(bus.mdstarte),  4'd0);
        check("rdiv_regwritem", 4'(bus.regwritem), 4'd0);
        check("rdiv_mdfunce",   4'(bus.mdfunce),   4'd0);
        reset = 1'b1;
        present(7'b0110011, 3'b000, 1'b0, 1'b0);
        tick;
        check("radd_busy",  4'(bus.mdbusye),  4'd0);
        check("radd_start", 4'(bus.mdstarte), 4'd0);
        nop;
        tick;
        check("radd_regwritem", 4'(bus.regwritem), 4'd1);
        tick;
        check("radd_regwritew",  4'(bus.regwritew),  4'd1);
        check("radd_resultsrcw", 4'(bus.resultsrcw), 4'd0);
        tick;

        // Back-to-back MUL then MULHU, MULLAT=2
        present(7'b0110011, 3'b000, 1'b0, 1'b1);
        tick;
        check("mul_start_c1", 4'(bus.mdstarte), 4'd1);
        check("mul_busy_c1",  4'(bus.mdbusye),  4'd0);
        present(7'b0110011, 3'b011, 1'b0, 1'b1);
        tick;
        check("mul_start_c2", 4'(bus.mdstarte), 4'd0);
        check("mul_busy_c2",  4'(bus.mdbusye),  4'd1);
        tick;
        check("mul_start_c3", 4'(bus.mdstarte), 4'd1);
        check("mul_busy_c3",  4'(bus.mdbusye),  4'd0);
        check("mul_func_c3",  4'(bus.mdfunce),  4'd3);
        nop;
        tick;
        check("mul_start_c4",     4'(bus.mdstarte),   4'd0);
        check("mul_busy_c4",      4'(bus.mdbusye),    4'd1);
        check("mul_regwritew_c4", 4'(bus.regwritew),  4'd1);
        check("mul_resultsrcw_c4", 4'(bus.resultsrcw), 4'd3);
        tick;
        check("mul_busy_c5",      4'(bus.mdbusye),   4'd0);
        check("mul_start_c5",     4'(bus.mdstarte),  4'd0);
        check("mul_regwritew_c5", 4'(bus.regwritew), 4'd0);
        tick;
        check("mul2_regwritew_c6", 4'(bus.regwritew), 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
